// File: rtl/dot_accumulator.sv
// Streaming dot-product accumulator: sums LEN unsigned 64-bit products, then
// holds the registered result until downstream consumes it.
module dot_accumulator #(
   parameter int unsigned LEN   = 4,
   parameter int unsigned ACC_W = 72
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_product,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [8:0]       acc_cnt
);

   localparam int unsigned PROD_W = 64;
   localparam int unsigned CNT_W  = 9;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

   if (LEN < 1 || LEN > 256 || ACC_W < PROD_W + $clog2(LEN)) begin : g_param_check
      $error("dot_accumulator: LEN must be 1..256 and ACC_W >= 64 + clog2(LEN)");
   end

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic             r_valid;

   logic [ACC_W-1:0] w_ext;
   logic [ACC_W-1:0] w_next;

   // A first product replaces stale accumulator contents instead of adding to them.
   assign w_ext  = ACC_W'(in_product);
   assign w_next = (r_cnt == '0) ? w_ext : r_acc + w_ext;

   assign in_ready  = (r_state == ACCUM);
   assign out_valid = r_valid;
   assign out_sum   = r_sum;
   assign acc_cnt   = r_cnt;

   // clear outranks both the input acceptance and the output handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ACCUM;
         r_acc   <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
      end else if (clear) begin
         r_state <= ACCUM;
         r_cnt   <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (in_valid) begin
                  if (r_cnt == LAST_CNT) begin
                     r_sum   <= w_next;
                     r_valid <= 1'b1;
                     r_cnt   <= '0;
                     r_state <= HOLD;
                  end else begin
                     r_acc <= w_next;
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               if (r_valid && out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= ACCUM;
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed self-checking bench for dot_accumulator (LEN=4, ACC_W=72).
module tb_dot_accumulator;

   localparam int unsigned LEN   = 4;
   localparam int unsigned ACC_W = 72;

   logic             clk = 1'b0;
   logic             rst;
   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      in_product;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_sum;
   logic [8:0]       acc_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   dot_accumulator #(.LEN(LEN), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_product(in_product),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .acc_cnt   (acc_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [63:0] p);
      in_valid   = 1'b1;
      in_product = p;
      tick();
      in_valid   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;
      #2;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_tests++; if (acc_cnt !== 9'd0) begin n_fail++; $display("FAIL reset_acc_cnt got %0d exp 0", acc_cnt); end
      n_tests++; if (out_sum !== 72'd0) begin n_fail++; $display("FAIL reset_out_sum got %0h exp 0", out_sum); end
      tick(); tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_basic();
      logic [8:0] exp_cnt [4] = '{9'd1, 9'd2, 9'd3, 9'd0};
      out_ready = 1'b1;
      n_tests++; if (acc_cnt !== 9'd0) begin n_fail++; $display("FAIL basic_cnt0 got %0d exp 0", acc_cnt); end
      for (int i = 0; i < 4; i++) begin
         feed(64'(i + 1));
         n_tests++; if (acc_cnt !== exp_cnt[i]) begin n_fail++; $display("FAIL basic_cnt[%0d] got %0d exp %0d", i, acc_cnt, exp_cnt[i]); end
         if (i < 3) begin
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid[%0d] got %b exp 0", i, out_valid); end
         end
      end
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", out_valid); end
      n_tests++; if (out_sum !== 72'd10) begin n_fail++; $display("FAIL basic_sum got %0d exp 10", out_sum); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_hold_ready got %b exp 0", in_ready); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle got %b exp 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_ready got %b exp 1", in_ready); end
      n_tests++; if (out_sum !== 72'd10) begin n_fail++; $display("FAIL basic_sum_kept got %0d exp 10", out_sum); end
   endtask

   task automatic test_max();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) feed(64'hFFFF_FFFF_FFFF_FFFF);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL max_valid got %b exp 1", out_valid); end
      n_tests++; if (out_sum !== 72'h03_FFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL max_sum got %0h exp 3fffffffffffffffc", out_sum); end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) feed(64'd1);
      in_valid = 1'b1; in_product = 64'd50;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", i, in_ready); end
         n_tests++; if (out_valid !== 1'b1 || out_sum !== 72'd4) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b s=%0d exp v=1 s=4", i, out_valid, out_sum); end
         n_tests++; if (acc_cnt !== 9'd0) begin n_fail++; $display("FAIL bp_cnt[%0d] got %0d exp 0", i, acc_cnt); end
      end
      out_ready = 1'b1;
      tick();
      n_tests++; if (out_valid !== 1'b0 || acc_cnt !== 9'd0) begin n_fail++; $display("FAIL bp_consume got v=%b cnt=%0d exp v=0 cnt=0", out_valid, acc_cnt); end
      tick();
      in_valid = 1'b0;
      n_tests++; if (acc_cnt !== 9'd1) begin n_fail++; $display("FAIL bp_next_accept got %0d exp 1", acc_cnt); end
      for (int i = 0; i < 3; i++) feed(64'd1);
      n_tests++; if (out_valid !== 1'b1 || out_sum !== 72'd53) begin n_fail++; $display("FAIL bp_sum2 got v=%b s=%0d exp v=1 s=53", out_valid, out_sum); end
      tick();
   endtask

   task automatic test_gaps();
      out_ready = 1'b1;
      feed(64'd5);
      for (int i = 0; i < 2; i++) begin
         in_product = 64'd999;
         tick();
         n_tests++; if (acc_cnt !== 9'd1) begin n_fail++; $display("FAIL gap_cnt[%0d] got %0d exp 1", i, acc_cnt); end
      end
      feed(64'd7); feed(64'd9); feed(64'd11);
      n_tests++; if (out_valid !== 1'b1 || out_sum !== 72'd32) begin n_fail++; $display("FAIL gap_sum got v=%b s=%0d exp v=1 s=32", out_valid, out_sum); end
      tick();
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      feed(64'd3); feed(64'd4);
      n_tests++; if (acc_cnt !== 9'd2) begin n_fail++; $display("FAIL clr_pre_cnt got %0d exp 2", acc_cnt); end
      clear = 1'b1;
      feed(64'd100);
      clear = 1'b0;
      n_tests++; if (acc_cnt !== 9'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL clr_state got cnt=%0d v=%b r=%b exp 0 0 1", acc_cnt, out_valid, in_ready); end
      for (int i = 0; i < 4; i++) feed(64'd1);
      n_tests++; if (out_valid !== 1'b1 || out_sum !== 72'd4) begin n_fail++; $display("FAIL clr_sum got v=%b s=%0d exp v=1 s=4", out_valid, out_sum); end
      // clear in HOLD beats a simultaneous consume and keeps out_sum
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 72'd4) begin n_fail++; $display("FAIL clr_hold got v=%b r=%b s=%0d exp 0 1 4", out_valid, in_ready, out_sum); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) feed(64'(i + 1));
      n_tests++; if (out_valid !== 1'b1 || out_sum !== 72'd10) begin n_fail++; $display("FAIL ar_pre got v=%b s=%0d exp v=1 s=10", out_valid, out_sum); end
      #3 rst = 1'b1;
      #1;
      n_tests++; if (out_valid !== 1'b0 || acc_cnt !== 9'd0) begin n_fail++; $display("FAIL ar_async got v=%b cnt=%0d exp 0 0", out_valid, acc_cnt); end
      n_tests++; if (in_ready !== 1'b1 || out_sum !== 72'd0) begin n_fail++; $display("FAIL ar_async2 got r=%b s=%0d exp 1 0", in_ready, out_sum); end
      #1 rst = 1'b0;
      feed(64'd2);
      n_tests++; if (acc_cnt !== 9'd1) begin n_fail++; $display("FAIL ar_first_accept got %0d exp 1", acc_cnt); end
      feed(64'd2); feed(64'd2); feed(64'd2);
      n_tests++; if (out_valid !== 1'b1 || out_sum !== 72'd8) begin n_fail++; $display("FAIL ar_sum got v=%b s=%0d exp v=1 s=8", out_valid, out_sum); end
      out_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_gaps();
      test_clear();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
